irq_arbiter: RTL and testbench

//  Multi-source interrupt controller in front of cp0. Synchronises N external
//  IRQ lines, latches rising edges as pending bits, applies a software mask and

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_sync_edge.sv | 36 +++
 rtl/irq_arbiter.sv | 146 ++++++++++++++
 tb/tb_irq_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: FSM states, register map, ID width.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GAP     = 2'd3
  } irq_state_e;

  localparam logic [1:0] CFG_MASK   = 2'd0;
  localparam logic [1:0] CFG_PEND   = 2'd1;
  localparam logic [1:0] CFG_STATUS = 2'd2;

  function automatic int id_w(input int n_src);
    return (n_src < 2) ? 1 : $clog2(n_src);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one async IRQ line followed by a registered
// rising-edge pulse (one pulse per low-to-high transition).
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt front end for cp0: edge capture, mask, fixed priority,
// and a request/taken/ERET/gap sequencer driving a single registered ir_out.
module irq_arbiter import irq_pkg::*; #(
  parameter int          N_SRC       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int          GAP_CYCLES  = 1,
  parameter logic [31:0] MASK_RST    = 32'h0,
  localparam int         ID_W        = id_w(N_SRC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic            ir_out,
  input  logic            ir_taken,
  input  logic            eret,
  output logic [ID_W-1:0] cur_id,
  output logic            busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  irq_state_e       state_q, state_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ir_out_q, ir_out_d;
  logic             busy_q, busy_d;

  logic [N_SRC-1:0] src_pulse;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] cur_bit;
  logic [N_SRC-1:0] pend_clr;
  logic [ID_W-1:0]  winner;
  logic             eret_clr;
  logic             unused_wdata;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (irq_src[g]),
      .pulse    (src_pulse[g])
    );
  end

  assign eligible     = pend_q & mask_q;
  assign cur_bit      = {{(N_SRC-1){1'b0}}, 1'b1} << cur_id_q;
  assign unused_wdata = ^cfg_wdata;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    gap_d    = gap_q;
    eret_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d  = ST_ASSERT;
          cur_id_d = winner;
        end
      end
      ST_ASSERT: begin
        if (ir_taken) begin
          state_d = ST_SERVICE;
        end else if (!eligible[cur_id_q]) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          eret_clr = 1'b1;
          state_d  = ST_GAP;
          gap_d    = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                                 gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    ir_out_d = (state_d == ST_ASSERT);
    busy_d   = (state_d == ST_ASSERT) || (state_d == ST_SERVICE);
  end

  // New edges are OR-ed in after the clear so a coincident set wins.
  always_comb begin
    pend_clr = '0;
    if (cfg_we && (cfg_addr == CFG_PEND)) pend_clr = cfg_wdata[N_SRC-1:0];
    if (eret_clr) pend_clr = pend_clr | cur_bit;
    pend_d = (pend_q & ~pend_clr) | src_pulse;
    mask_d = (cfg_we && (cfg_addr == CFG_MASK)) ? cfg_wdata[N_SRC-1:0] : mask_q;
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_MASK:   cfg_rdata[N_SRC-1:0] = mask_q;
      CFG_PEND:   cfg_rdata[N_SRC-1:0] = pend_q;
      CFG_STATUS: begin
        cfg_rdata[9:8]      = state_q;
        cfg_rdata[ID_W-1:0] = cur_id_q;
      end
      default:    cfg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cur_id_q <= '0;
      pend_q   <= '0;
      mask_q   <= MASK_RST[N_SRC-1:0];
      gap_q    <= '0;
      ir_out_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      gap_q    <= gap_d;
      ir_out_q <= ir_out_d;
      busy_q   <= busy_d;
    end
  end

  assign ir_out = ir_out_q;
  assign busy   = busy_q;
  assign cur_id = cur_id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios with a cur_id scoreboard.
module tb_irq_arbiter;
  import irq_pkg::*;

  localparam int          N_SRC       = 8;
  localparam int          SYNC_STAGES = 2;
  localparam int          GAP_CYCLES  = 1;
  localparam logic [31:0] MASK_RST    = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_src = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        ir_out;
  logic        ir_taken = 1'b0;
  logic        eret = 1'b0;
  logic [2:0]  cur_id;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  irq_arbiter #(
    .N_SRC(N_SRC), .SYNC_STAGES(SYNC_STAGES), .GAP_CYCLES(GAP_CYCLES), .MASK_RST(MASK_RST)
  ) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .ir_out(ir_out), .ir_taken(ir_taken),
    .eret(eret), .cur_id(cur_id), .busy(busy)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic take();
    ir_taken = 1'b1;
    step(1);
    ir_taken = 1'b0;
  endtask

  task automatic eret_p();
    eret = 1'b1;
    step(1);
    eret = 1'b0;
  endtask

  task automatic wait_ir(input string tag, input logic lvl, input int budget);
    int n = 0;
    while (ir_out !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(ir_out), 32'(lvl));
  endtask

  // Scoreboard pop: compare cur_id against the oldest expected request.
  task automatic sb_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk(tag, 32'(cur_id), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(cur_id), e);
    end
  endtask

  initial begin
    // Reset
    step(3);
    rst = 1'b0;
    chk("rst_ir_out", 32'(ir_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cur_id", 32'(cur_id), 0);
    chk_reg("rst_pend", CFG_PEND, 32'h0);
    chk_reg("rst_mask", CFG_MASK, MASK_RST);
    chk_reg("rst_status", CFG_STATUS, 32'h0);

    // 1: single source, capture latency and request
    wr(CFG_MASK, 32'h05);
    irq_src[2] = 1'b1;
    exp_q.push_back(32'd2);
    step(3);
    chk_reg("t1_pend_early", CFG_PEND, 32'h00);
    step(1);
    chk_reg("t1_pend", CFG_PEND, 32'h04);
    chk("t1_ir_low", 32'(ir_out), 0);
    step(1);
    chk("t1_ir_high", 32'(ir_out), 1);
    chk("t1_busy", 32'(busy), 1);
    sb_pop("t1_cur_id");
    irq_src[2] = 1'b0;

    // 2: taken, service, eret, gap
    take();
    chk("t2_ir_service", 32'(ir_out), 0);
    chk("t2_busy_service", 32'(busy), 1);
    chk_reg("t2_status_service", CFG_STATUS, 32'h202);
    step(5);
    eret_p();
    chk("t2_ir_gap", 32'(ir_out), 0);
    chk("t2_busy_gap", 32'(busy), 0);
    chk_reg("t2_pend_cleared", CFG_PEND, 32'h00);
    chk_reg("t2_status_gap", CFG_STATUS, 32'h302);
    step(1);
    chk("t2_ir_idle", 32'(ir_out), 0);
    chk_reg("t2_status_idle", CFG_STATUS, 32'h002);
    take();
    eret_p();
    chk_reg("t2_ignored_events", CFG_STATUS, 32'h002);

    // 3: priority, minimum gap, coincident taken+eret, level = one event
    wr(CFG_MASK, 32'hFF);
    irq_src[5] = 1'b1;
    irq_src[1] = 1'b1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd5);
    wait_ir("t3_wait_first", 1'b1, 10);
    sb_pop("t3_first");
    chk_reg("t3_pend_both", CFG_PEND, 32'h22);
    take();
    step(2);
    eret_p();
    chk("t3_gap_low0", 32'(ir_out), 0);
    step(1);
    chk("t3_gap_low1", 32'(ir_out), 0);
    step(1);
    chk("t3_second_high", 32'(ir_out), 1);
    sb_pop("t3_second");
    ir_taken = 1'b1;
    eret     = 1'b1;
    step(1);
    ir_taken = 1'b0;
    eret     = 1'b0;
    chk_reg("t3_taken_eret_status", CFG_STATUS, 32'h205);
    chk_reg("t3_taken_eret_pend", CFG_PEND, 32'h20);
    step(1);
    eret_p();
    step(2);
    chk_reg("t3_level_one_event", CFG_PEND, 32'h00);
    chk("t3_idle_low", 32'(ir_out), 0);
    irq_src = '0;

    // 4: withdraw by masking, then re-request
    wr(CFG_MASK, 32'h08);
    irq_src[3] = 1'b1;
    exp_q.push_back(32'd3);
    wait_ir("t4_wait", 1'b1, 10);
    sb_pop("t4_cur_id");
    irq_src[3] = 1'b0;
    wr(CFG_MASK, 32'h00);
    step(1);
    chk("t4_withdrawn", 32'(ir_out), 0);
    chk("t4_busy", 32'(busy), 0);
    chk_reg("t4_status_gap", CFG_STATUS, 32'h303);
    chk_reg("t4_pend_kept", CFG_PEND, 32'h08);
    exp_q.push_back(32'd3);
    wr(CFG_MASK, 32'h08);
    wait_ir("t4_wait_reassert", 1'b1, 5);
    sb_pop("t4_reassert");

    // 5: new edge on cur_id's source coincides with eret
    take();
    irq_src[3] = 1'b1;
    step(3);
    eret_p();
    chk_reg("t5_pend_set_wins", CFG_PEND, 32'h08);
    chk_reg("t5_status_gap", CFG_STATUS, 32'h303);
    exp_q.push_back(32'd3);
    step(1);
    chk("t5_gap_low", 32'(ir_out), 0);
    step(1);
    chk("t5_rerequest", 32'(ir_out), 1);
    sb_pop("t5_cur_id");
    take();
    eret_p();
    irq_src[3] = 1'b0;
    step(4);

    // 6: reset during service
    wr(CFG_MASK, 32'h0A);
    irq_src[1] = 1'b1;
    irq_src[3] = 1'b1;
    exp_q.push_back(32'd1);
    wait_ir("t6_wait", 1'b1, 10);
    sb_pop("t6_cur_id");
    take();
    chk_reg("t6_pend_before", CFG_PEND, 32'h0A);
    chk_reg("t6_status_before", CFG_STATUS, 32'h201);
    rst     = 1'b1;
    irq_src = '0;
    step(1);
    chk("t6_ir_out", 32'(ir_out), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cur_id", 32'(cur_id), 0);
    chk_reg("t6_pend", CFG_PEND, 32'h00);
    chk_reg("t6_mask", CFG_MASK, MASK_RST);
    chk_reg("t6_status", CFG_STATUS, 32'h000);
    rst = 1'b0;
    step(6);
    chk_reg("t6_pend_discarded", CFG_PEND, 32'h00);
    chk("t6_ir_quiet", 32'(ir_out), 0);

    // Software clear of a masked pending bit
    irq_src[7] = 1'b1;
    step(5);
    chk_reg("w1c_pend_set", CFG_PEND, 32'h80);
    chk("w1c_masked_no_req", 32'(ir_out), 0);
    wr(CFG_PEND, 32'h80);
    chk_reg("w1c_pend_cleared", CFG_PEND, 32'h00);
    irq_src[7] = 1'b0;

    chk("sb_drained", 32'(exp_q.size()), 0);

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
